// File: rtl/wide_adder_seq_if.sv
// Operand/result handshake bundle for wide_adder_seq.
// The master side produces operands and consumes results; the slave side is the adder.
interface wide_adder_seq_if #(
    parameter int WIDTH = 100
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/wide_adder_seq.sv
// Time-shared ripple-carry adder: a + b + cin over WIDTH bits, CHUNK bits per clock,
// with a registered carry between chunks and per-bit sum/carry-out result registers.
module wide_adder_seq #(
    parameter int WIDTH = 100,
    parameter int CHUNK = 10
) (
    input  logic           clk,
    input  logic           reset,
    wide_adder_seq_if.slave bus
);
    localparam int NUM_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int IDXW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_cout;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s;
    logic [CHUNK-1:0] w_co;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_cout_next;
    logic             w_carry_next;
    logic             w_accept;

    assign w_accept = bus.in_valid && r_in_ready;

    // Lanes beyond WIDTH in the final chunk read as zero and are never written back,
    // so they cannot disturb the result or the final carry.
    always_comb begin : chunk_slice
        logic w_c;
        w_a_chunk    = '0;
        w_b_chunk    = '0;
        w_sum_next   = r_sum;
        w_cout_next  = r_cout;
        w_carry_next = r_carry;
        for (int j = 0; j < WIDTH; j++) begin
            if (r_idx == IDXW'(j / CHUNK)) begin
                w_a_chunk[j % CHUNK] = r_a[j];
                w_b_chunk[j % CHUNK] = r_b[j];
            end
        end
        w_c = r_carry;
        for (int i = 0; i < CHUNK; i++) begin
            w_s[i]  = w_a_chunk[i] ^ w_b_chunk[i] ^ w_c;
            w_co[i] = (w_a_chunk[i] & w_b_chunk[i]) | (w_a_chunk[i] & w_c) | (w_b_chunk[i] & w_c);
            w_c     = w_co[i];
        end
        for (int j = 0; j < WIDTH; j++) begin
            if (r_idx == IDXW'(j / CHUNK)) begin
                w_sum_next[j]  = w_s[j % CHUNK];
                w_cout_next[j] = w_co[j % CHUNK];
                if ((j % CHUNK == CHUNK - 1) || (j == WIDTH - 1)) begin
                    w_carry_next = w_co[j % CHUNK];
                end
            end
        end
    end

    // Operand capture carries no reset: these registers are only read after a capture.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= bus.a;
            r_b <= bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx      <= '0;
                        r_carry    <= bus.cin;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_cout  <= w_cout_next;
                    r_carry <= w_carry_next;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == IDXW'(NUM_CHUNKS - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // in_ready stays low this cycle, leaving one bubble before the next capture.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: doc/wide_adder_seq.md
Name: wide_adder_seq

Overview:
- Multi-cycle sequencer for a WIDTH-bit ripple-carry add (a + b + cin) producing a per-bit sum and a per-bit carry-out vector.
- Processes CHUNK bits per clock with a registered inter-chunk carry, so one short adder slice is time-shared across the full operand.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 100, operand/result width in bits.
- CHUNK, 10, bits processed per RUN cycle; 1 <= CHUNK <= WIDTH; need not divide WIDTH.
- NUM_CHUNKS, derived ceil(WIDTH/CHUNK), not overridable; default 10.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b, cin valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  sum/cout hold a completed result.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  sum[i] = a[i]^b[i]^c(i), with c(0)=cin and c(i)=cout[i-1].
- cout  out  WIDTH  cout[i] = majority(a[i], b[i], c(i)); cout[WIDTH-1] is the final carry.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset is synchronous and active-high: in the cycle after reset is sampled high, state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, chunk index=0, carry reg=0. Reset has priority over all other events, including mid-RUN and in DONE. An aborted operation produces no result.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b, cin into internal registers; idx<=0; carry reg<=cin; go to RUN.
  - sum/cout keep their previous values and are not cleared.
- RUN:
  - in_ready=0; in_valid and a/b/cin are ignored.
  - Each cycle, compute bits [idx*CHUNK +: CHUNK] as a ripple chain from the carry reg.
  - Write the results into the corresponding slices of sum and cout.
  - carry reg <= cout of the chunk's top valid bit; idx <= idx+1.
  - On the cycle processing idx = NUM_CHUNKS-1, go to DONE.
- Partial last chunk: only bits < WIDTH are written. Out-of-range lanes are discarded and never affect cout[WIDTH-1].
- DONE:
  - out_valid=1; sum and cout are stable and complete.
  - Hold until out_ready=1; on out_valid&out_ready, go to IDLE and out_valid<=0.
  - in_ready=0 in DONE, so a new operand cannot be accepted in the same cycle as result retirement. This gives one bubble cycle; throughput is one op per NUM_CHUNKS+2 cycles minimum.
- Latency: if operands are accepted at edge k, out_valid is high after edge k+NUM_CHUNKS (10 cycles at default).
- out_ready while not in DONE is ignored.
- Arithmetic: {cout[WIDTH-1], sum} must equal a + b + cin, zero-extended to WIDTH+1 bits. cout[i] must be the true ripple carry at every bit, including across chunk boundaries.
- sum/cout outputs are registers, with no combinational path from a/b/cin.
- busy = (state != IDLE).

Test Plan:
- a=0, b=0, cin=1, accept at edge k -> out_valid rises after edge k+10; sum=1; cout all zeros; busy high for exactly 10 RUN + DONE cycles.
- a=2^100-1, b=0, cin=1 -> sum=0; cout all ones (carry crosses all 9 chunk boundaries); cout[99]=1.
- a=2^99, b=2^99, cin=0 -> sum=0; cout[99]=1; cout[98:0]=0. Then a=0x5555…5 (alternating pattern), b=0xAAAA…A, cin=0 -> sum all ones, cout all zeros.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands -> out_valid, sum, cout stable; in_ready=0; new operands not captured. Pulse out_ready -> IDLE next cycle, in_ready=1.
- Reset asserted during RUN at idx=4 -> next cycle IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Then a=123456789, b=987654321, cin=0 -> sum=1111111110, correct result after 10 cycles.
- CHUNK=7 (NUM_CHUNKS=15, partial last chunk of 2 bits), 1000 random a/b/cin with random out_ready stalls -> every result matches a+b+cin with per-bit cout; latency 15; no X on outputs after reset.
